// File: rtl/npu_cube_csa_resolve_pkg.sv
// Shared constants and types for the NPU cube CSA resolve stage.
// Lane widths are offsets from operand-B width; lane k sits at bit offset 2*k.
package npu_cube_pkg;

  localparam int unsigned LANE0_SUM_EXT = 5;
  localparam int unsigned LANE0_CAY_EXT = 4;
  localparam int unsigned LANEN_SUM_EXT = 3;
  localparam int unsigned LANEN_CAY_EXT = 2;

  localparam int unsigned LANE_SHIFT0 = 0;
  localparam int unsigned LANE_SHIFT1 = 2;
  localparam int unsigned LANE_SHIFT2 = 4;
  localparam int unsigned LANE_SHIFT3 = 6;

  typedef enum logic {ACC, FULL} state_e;

  function automatic int unsigned lane_sum_w(input int unsigned dwb, input int unsigned lane);
    return dwb + ((lane == 0) ? LANE0_SUM_EXT : LANEN_SUM_EXT);
  endfunction

  function automatic int unsigned lane_cay_w(input int unsigned dwb, input int unsigned lane);
    return dwb + ((lane == 0) ? LANE0_CAY_EXT : LANEN_CAY_EXT);
  endfunction

endpackage

// File: rtl/npu_cube_csa_resolve_if.sv
// Beat input and result output handshake bundle of the CSA resolve stage.
// out_sat exists only when NPU_CUBE_RESOLVE_SAT_EN is defined.
interface npu_cube_csa_resolve_if #(
  parameter int unsigned DWB = 8,
  parameter int unsigned DWS = 21
);
  import npu_cube_pkg::*;

  logic                                in_valid;
  logic                                in_ready;
  logic [DWB+LANE0_SUM_EXT-1:0]        l3_linesum0;
  logic [DWB+LANE0_CAY_EXT-1:0]        l3_linecay0;
  logic [DWB+LANEN_SUM_EXT-1:0]        l3_linesum1;
  logic [DWB+LANEN_CAY_EXT-1:0]        l3_linecay1;
  logic [DWB+LANEN_SUM_EXT-1:0]        l3_linesum2;
  logic [DWB+LANEN_CAY_EXT-1:0]        l3_linecay2;
  logic [DWB+LANEN_SUM_EXT-1:0]        l3_linesum3;
  logic [DWB+LANEN_CAY_EXT-1:0]        l3_linecay3;
  logic                                out_valid;
  logic                                out_ready;
  logic [DWS-1:0]                      out_data;
  logic                                out_busy;
`ifdef NPU_CUBE_RESOLVE_SAT_EN
  logic                                out_sat;

  modport master (
    output in_valid, l3_linesum0, l3_linecay0, l3_linesum1, l3_linecay1,
           l3_linesum2, l3_linecay2, l3_linesum3, l3_linecay3, out_ready,
    input  in_ready, out_valid, out_data, out_busy, out_sat
  );
  modport slave (
    input  in_valid, l3_linesum0, l3_linecay0, l3_linesum1, l3_linecay1,
           l3_linesum2, l3_linecay2, l3_linesum3, l3_linecay3, out_ready,
    output in_ready, out_valid, out_data, out_busy, out_sat
  );
`else
  modport master (
    output in_valid, l3_linesum0, l3_linecay0, l3_linesum1, l3_linecay1,
           l3_linesum2, l3_linecay2, l3_linesum3, l3_linecay3, out_ready,
    input  in_ready, out_valid, out_data, out_busy
  );
  modport slave (
    input  in_valid, l3_linesum0, l3_linecay0, l3_linesum1, l3_linecay1,
           l3_linesum2, l3_linecay2, l3_linesum3, l3_linecay3, out_ready,
    output in_ready, out_valid, out_data, out_busy
  );
`endif

endinterface

// File: rtl/npu_cube_csa_resolve_lane_cpa.sv
// Carry-propagate resolve of one CSA lane: v = sum + (cay << 1).
module npu_cube_lane_cpa #(
  parameter int unsigned SW = 13,
  parameter int unsigned CW = 12,
  parameter int unsigned VW = 14
) (
  input  logic [SW-1:0] sum_i,
  input  logic [CW-1:0] cay_i,
  output logic [VW-1:0] v_o
);

  always_comb begin
    v_o = VW'(sum_i) + (VW'(cay_i) << 1);
  end

endmodule

// File: rtl/npu_cube_csa_resolve.sv
// Resolves CSA lane pairs to a partial product (2-stage pipe) and accumulates
// NPU_CUBE_MAC_NUM beats per result. Define NPU_CUBE_RESOLVE_SAT_EN for saturation.
module npu_cube_csa_resolve
  import npu_cube_pkg::*;
#(
  parameter int unsigned DWB              = 8,
  parameter int unsigned DWPRODUCT        = 19,
  parameter int unsigned DWS              = 21,
  parameter int unsigned NPU_CUBE_MAC_NUM = 8,
  parameter int unsigned SIGNED_A         = 0
) (
  input logic                   clk,
  input logic                   rst,
  npu_cube_csa_resolve_if.slave io
);

  localparam int unsigned VW0    = lane_sum_w(DWB, 0) + 1;
  localparam int unsigned VWN    = lane_sum_w(DWB, 1) + 1;
  localparam int unsigned CNT_W  = $clog2(NPU_CUBE_MAC_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPU_CUBE_MAC_NUM - 1);
  localparam bit          SGN    = (SIGNED_A != 0);

  logic [VW0-1:0] v0;
  logic [VWN-1:0] v1, v2, v3;

  npu_cube_lane_cpa #(.SW(lane_sum_w(DWB, 0)), .CW(lane_cay_w(DWB, 0)), .VW(VW0)) u_lane0 (
    .sum_i(io.l3_linesum0), .cay_i(io.l3_linecay0), .v_o(v0));
  npu_cube_lane_cpa #(.SW(lane_sum_w(DWB, 1)), .CW(lane_cay_w(DWB, 1)), .VW(VWN)) u_lane1 (
    .sum_i(io.l3_linesum1), .cay_i(io.l3_linecay1), .v_o(v1));
  npu_cube_lane_cpa #(.SW(lane_sum_w(DWB, 2)), .CW(lane_cay_w(DWB, 2)), .VW(VWN)) u_lane2 (
    .sum_i(io.l3_linesum2), .cay_i(io.l3_linecay2), .v_o(v2));
  npu_cube_lane_cpa #(.SW(lane_sum_w(DWB, 3)), .CW(lane_cay_w(DWB, 3)), .VW(VWN)) u_lane3 (
    .sum_i(io.l3_linesum3), .cay_i(io.l3_linecay3), .v_o(v3));

  logic                 s1_valid_q, s1_valid_d;
  logic [VW0-1:0]       s1_v0_q, s1_v0_d;
  logic [VWN-1:0]       s1_v1_q, s1_v1_d, s1_v2_q, s1_v2_d, s1_v3_q, s1_v3_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [DWPRODUCT-1:0] s2_p_q, s2_p_d;
  logic [DWS-1:0]       acc_q, acc_d, out_data_q, out_data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  state_e               state_q, state_d;

  logic                 en, complete;
  logic [DWPRODUCT-1:0] prod;
  logic [DWS-1:0]       ext_p, acc_sum;
`ifdef NPU_CUBE_RESOLVE_SAT_EN
  logic                 sat_q, sat_d, out_sat_q, out_sat_d;
  logic [DWS:0]         wide;
  logic                 clamp;
`endif

  always_comb begin
    prod = DWPRODUCT'(s1_v0_q) + (DWPRODUCT'(s1_v1_q) << LANE_SHIFT1)
         + (DWPRODUCT'(s1_v2_q) << LANE_SHIFT2) + (DWPRODUCT'(s1_v3_q) << LANE_SHIFT3);
    ext_p = {{(DWS-DWPRODUCT){SGN & s2_p_q[DWPRODUCT-1]}}, s2_p_q};
`ifdef NPU_CUBE_RESOLVE_SAT_EN
    // One guard bit: signed overflow shows as the top two bits disagreeing.
    wide  = {SGN & acc_q[DWS-1], acc_q} + {SGN & ext_p[DWS-1], ext_p};
    clamp = SGN ? (wide[DWS] ^ wide[DWS-1]) : wide[DWS];
    if (!clamp)    acc_sum = wide[DWS-1:0];
    else if (!SGN) acc_sum = '1;
    else           acc_sum = {wide[DWS], {(DWS-1){~wide[DWS]}}};
`else
    acc_sum = acc_q + ext_p;
`endif
  end

  always_comb begin
    en          = !out_valid_q | io.out_ready;
    complete    = s2_valid_q && (cnt_q == CNT_LAST);
    s1_valid_d  = s1_valid_q;
    s1_v0_d     = s1_v0_q;
    s1_v1_d     = s1_v1_q;
    s1_v2_d     = s1_v2_q;
    s1_v3_d     = s1_v3_q;
    s2_valid_d  = s2_valid_q;
    s2_p_d      = s2_p_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
`ifdef NPU_CUBE_RESOLVE_SAT_EN
    sat_d       = sat_q;
    out_sat_d   = out_sat_q;
`endif
    if (en) begin
      s1_valid_d = io.in_valid;
      s1_v0_d    = v0;
      s1_v1_d    = v1;
      s1_v2_d    = v2;
      s1_v3_d    = v3;
      s2_valid_d = s1_valid_q;
      s2_p_d     = prod;
      if (complete) begin
        out_data_d  = acc_sum;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = FULL;
`ifdef NPU_CUBE_RESOLVE_SAT_EN
        out_sat_d   = sat_q | clamp;
        sat_d       = 1'b0;
`endif
      end else begin
        if (s2_valid_q) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
`ifdef NPU_CUBE_RESOLVE_SAT_EN
          sat_d = sat_q | clamp;
`endif
        end
        if (state_q == FULL) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_v0_q     <= '0;
      s1_v1_q     <= '0;
      s1_v2_q     <= '0;
      s1_v3_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_p_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      state_q     <= ACC;
`ifdef NPU_CUBE_RESOLVE_SAT_EN
      sat_q       <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_v0_q     <= s1_v0_d;
      s1_v1_q     <= s1_v1_d;
      s1_v2_q     <= s1_v2_d;
      s1_v3_q     <= s1_v3_d;
      s2_valid_q  <= s2_valid_d;
      s2_p_q      <= s2_p_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
`ifdef NPU_CUBE_RESOLVE_SAT_EN
      sat_q       <= sat_d;
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign io.in_ready  = en;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_busy  = s1_valid_q | s2_valid_q | (cnt_q != '0);
`ifdef NPU_CUBE_RESOLVE_SAT_EN
  assign io.out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_npu_cube_csa_resolve.sv
// Directed bench: an unsigned and a signed instance share one stimulus stream,
// each result checked against hand-computed values.
module tb_npu_cube_csa_resolve;

  localparam int unsigned DWB = 8;
  localparam int unsigned DWS = 21;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic [12:0] b_s0;
  logic [11:0] b_c0;
  logic [10:0] b_s1, b_s2, b_s3;
  logic [9:0]  b_c1, b_c2, b_c3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int u_vcnt = 0;
  int ir_low = 0;
  int last_cyc = 0;
  logic [DWS-1:0] uq[$];
  logic [DWS-1:0] sq[$];
  int cq[$];
  logic usq[$];
  logic ssq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npu_cube_csa_resolve_if #(.DWB(DWB), .DWS(DWS)) uif ();
  npu_cube_csa_resolve_if #(.DWB(DWB), .DWS(DWS)) sif ();

  assign uif.in_valid = in_valid;     assign sif.in_valid = in_valid;
  assign uif.out_ready = out_ready;   assign sif.out_ready = out_ready;
  assign uif.l3_linesum0 = b_s0;      assign sif.l3_linesum0 = b_s0;
  assign uif.l3_linecay0 = b_c0;      assign sif.l3_linecay0 = b_c0;
  assign uif.l3_linesum1 = b_s1;      assign sif.l3_linesum1 = b_s1;
  assign uif.l3_linecay1 = b_c1;      assign sif.l3_linecay1 = b_c1;
  assign uif.l3_linesum2 = b_s2;      assign sif.l3_linesum2 = b_s2;
  assign uif.l3_linecay2 = b_c2;      assign sif.l3_linecay2 = b_c2;
  assign uif.l3_linesum3 = b_s3;      assign sif.l3_linesum3 = b_s3;
  assign uif.l3_linecay3 = b_c3;      assign sif.l3_linecay3 = b_c3;

  npu_cube_csa_resolve #(.DWB(8), .DWPRODUCT(19), .DWS(21), .NPU_CUBE_MAC_NUM(8), .SIGNED_A(0))
    u_dut (.clk(clk), .rst(rst), .io(uif.slave));
  npu_cube_csa_resolve #(.DWB(8), .DWPRODUCT(19), .DWS(21), .NPU_CUBE_MAC_NUM(8), .SIGNED_A(1))
    s_dut (.clk(clk), .rst(rst), .io(sif.slave));

  always @(negedge clk) begin
    if (uif.out_valid) u_vcnt++;
    if (!uif.in_ready) ir_low++;
    if (uif.out_valid && out_ready) begin
      uq.push_back(uif.out_data);
      cq.push_back(cyc);
`ifdef NPU_CUBE_RESOLVE_SAT_EN
      usq.push_back(uif.out_sat);
`endif
    end
    if (sif.out_valid && out_ready) begin
      sq.push_back(sif.out_data);
`ifdef NPU_CUBE_RESOLVE_SAT_EN
      ssq.push_back(sif.out_sat);
`endif
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    b_s0 = '0; b_c0 = '0; b_s1 = '0; b_c1 = '0;
    b_s2 = '0; b_c2 = '0; b_s3 = '0; b_c3 = '0;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [12:0] a0, input logic [11:0] k0,
                      input logic [10:0] a1, input logic [9:0] k1,
                      input logic [10:0] a2, input logic [9:0] k2,
                      input logic [10:0] a3, input logic [9:0] k3);
    bit ok = 1'b0;
    int w = 0;
    in_valid = 1'b1;
    b_s0 = a0; b_c0 = k0; b_s1 = a1; b_c1 = k1;
    b_s2 = a2; b_c2 = k2; b_s3 = a3; b_c3 = k3;
    while (!ok && w < 200) begin
      @(negedge clk);
      if (uif.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      w++;
    end
    if (!ok) check("send_accept", ok, 1);
  endtask

  task automatic send_p0(input logic [12:0] a0, input int n);
    for (int i = 0; i < n; i++) send(a0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_res(input int n);
    int w = 0;
    while ((uq.size() < n || sq.size() < n) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (uq.size() < n) check("result_timeout", uq.size(), n);
    sync();
  endtask

  task automatic pop_check(input string tag, input logic [DWS-1:0] exp_u, input logic [DWS-1:0] exp_s,
                           input logic exp_usat, input logic exp_ssat);
    logic [DWS-1:0] gu, gs;
    gu = (uq.size() != 0) ? uq.pop_front() : 'x;
    gs = (sq.size() != 0) ? sq.pop_front() : 'x;
    last_cyc = (cq.size() != 0) ? cq.pop_front() : -1;
    check({tag, "_u"}, gu, exp_u);
    check({tag, "_s"}, gs, exp_s);
`ifdef NPU_CUBE_RESOLVE_SAT_EN
    check({tag, "_usat"}, (usq.size() != 0) ? usq.pop_front() : 1'bx, exp_usat);
    check({tag, "_ssat"}, (ssq.size() != 0) ? ssq.pop_front() : 1'bx, exp_ssat);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_acc, c1;
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", uif.out_valid, 0);
    check("rst_out_data", uif.out_data, 0);
    check("rst_in_ready", uif.in_ready, 1);
    check("rst_out_busy", uif.out_busy, 0);
    sync();

    // V0 = 5 + 2*3 = 11 per beat.
    u_vcnt = 0;
    for (int i = 0; i < 8; i++) send(5, 3, 0, 0, 0, 0, 0, 0);
    t_acc = cyc;
    idle();
    wait_res(1);
    pop_check("sum88", 88, 88, 0, 0);
    check("latency", last_cyc, t_acc + 2);
    repeat (4) @(negedge clk);
    check("valid_one_cycle", u_vcnt, 1);
    check("busy_idle", uif.out_busy, 0);
    sync();

    // Lane shifts: V3=1 -> 64, V1=2 -> 8.
    send(0, 0, 0, 0, 0, 0, 1, 0);
    send_p0(0, 7);
    idle();
    wait_res(1);
    pop_check("lane3", 64, 64, 0, 0);
    send(0, 0, 0, 1, 0, 0, 0, 0);
    send_p0(0, 7);
    idle();
    wait_res(1);
    pop_check("lane1", 8, 8, 0, 0);

    ir_low = 0;
    send_p0(1, 16);
    idle();
    wait_res(2);
    check("b2b_in_ready", ir_low, 0);
    pop_check("b2b_g0", 8, 8, 0, 0);
    c1 = last_cyc;
    pop_check("b2b_g1", 8, 8, 0, 0);
    check("b2b_gap", last_cyc - c1, 8);

    out_ready = 1'b0;
    send_p0(1, 8);
    fork
      begin
        send_p0(2, 8);
        idle();
      end
      begin
        int w = 0;
        while (!uif.out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        check("stall_valid", uif.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", uif.in_ready, 0);
          check("stall_data", uif.out_data, 8);
        end
        sync();
        out_ready = 1'b1;
      end
    join
    wait_res(2);
    pop_check("stall_g0", 8, 8, 0, 0);
    pop_check("stall_g1", 16, 16, 0, 0);

    // P = 240 + 4093*16 + 4093*64 = 327680 (bit 18 set).
    send(240, 0, 0, 0, 2047, 1023, 2047, 1023);
    send(240, 0, 0, 0, 2047, 1023, 2047, 1023);
    send_p0(0, 6);
    idle();
    wait_res(1);
    pop_check("signext", 21'h0A0000, 21'h1A0000, 0, 0);

`ifdef NPU_CUBE_RESOLVE_SAT_EN
    // P = 360193 (max): unsigned clamps high, signed (-164095) clamps low.
    for (int i = 0; i < 8; i++) send(8191, 4095, 2047, 1023, 2047, 1023, 2047, 1023);
    idle();
    wait_res(1);
    pop_check("sat_max", 21'h1FFFFF, 21'h100000, 1, 1);
    // P = 262143: signed clamps at 2^20-1, unsigned fits.
    for (int i = 0; i < 8; i++) send(191, 0, 0, 0, 0, 0, 2047, 1023);
    idle();
    wait_res(1);
    pop_check("sat_pos", 21'h1FFFF8, 21'h0FFFFF, 0, 1);
`endif

    send_p0(1, 4);
    idle();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", uif.out_busy, 0);
    check("midrst_valid", uif.out_valid, 0);
    repeat (5) @(negedge clk);
    check("midrst_no_result", uq.size() + sq.size(), 0);
    sync();
    send_p0(2, 8);
    idle();
    wait_res(1);
    pop_check("after_rst", 16, 16, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
